// File: rtl/udp_recv_pkg.sv
// Shared definitions for the UDP frame receiver: FSM encoding, header layout
// and the payload-size rule.
package udp_recv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_ADDR     = 3'd2,
        ST_RECV     = 3'd3,
        ST_ISSUE    = 3'd4,
        ST_WAIT_END = 3'd5,
        ST_DROP     = 3'd6
    } recv_state_t;

    localparam int         HDR_LEN   = 4;      // header words before the offset word
    localparam int         HDR_L_IDX = 3;      // header word carrying the byte length
    localparam logic [3:0] DATA_STRB = 4'hF;   // every data word is fully valid

    // Payload words = bytes rounded up to words, minus the two trailing
    // non-payload words. Done in 32 bits so tiny lengths wrap to huge values.
    function automatic logic [31:0] payload_words(input logic [31:0] len_bytes);
        logic [31:0] v_words;
        v_words = (len_bytes + 32'd3) >> 2;
        return v_words - 32'd2;
    endfunction

endpackage

// File: rtl/udp_burst_splitter.sv
// Splits one packet's payload into DRAM write commands of at most MAX_BURST
// words. The command on o_ctrl_in is held while the command FIFO is full.
module udp_burst_splitter
    import udp_recv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [31:0]           i_words,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic                  i_issue,
    input  logic                  i_ctrl_full,
    output logic [ADDR_WIDTH+7:0] o_ctrl_in,
    output logic                  o_ctrl_we,
    output logic                  o_last
);

    localparam logic [31:0]           BURST_W     = 32'(MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(MAX_BURST * 4);

    logic [31:0]           r_rem;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            w_len;
    logic                  w_fits;

    // Length of the command currently offered: remainder or a full burst
    always_comb begin
        w_fits = (r_rem <= BURST_W);
        if (w_fits) begin
            w_len = r_rem[7:0];
        end else begin
            w_len = BURST_W[7:0];
        end
    end

    assign o_ctrl_we = i_issue & ~i_ctrl_full;
    assign o_last    = o_ctrl_we & w_fits;
    assign o_ctrl_in = {w_len, r_addr};

    // Remaining-words and address bookkeeping, advanced only on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= 32'd0;
            r_addr <= '0;
        end else if (i_load) begin
            r_rem  <= i_words;
            r_addr <= i_base;
        end else if (o_ctrl_we) begin
            r_rem  <= r_rem - {24'd0, w_len};
            r_addr <= r_addr + BURST_BYTES;
        end else begin
            r_rem  <= r_rem;
            r_addr <= r_addr;
        end
    end

endmodule

// File: rtl/udp_frame_dma_recv.sv
// Receives one UDP packet per r_enable burst, streams its payload into the
// data FIFO and queues DRAM write commands into the frame buffer being filled.
module udp_frame_dma_recv
    import udp_recv_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          MAX_BURST    = 64,
    parameter int          NUM_FRAMES   = 2,
    parameter logic [31:0] FRAME_STRIDE = 32'h0200_0000,
    parameter int          MAX_WORDS    = 512,
    localparam int         FS_W         = $clog2(NUM_FRAMES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_req,
    input  logic                  r_enable,
    output logic                  r_ack,
    input  logic [31:0]           r_data,
    output logic                  w_req,
    output logic                  w_enable,
    input  logic                  w_ack,
    output logic [31:0]           w_data,
    output logic [35:0]           data_in,
    output logic                  data_we,
    input  logic                  data_full,
    output logic [ADDR_WIDTH+7:0] ctrl_in,
    output logic                  ctrl_we,
    input  logic                  ctrl_full,
    output logic [FS_W-1:0]       frame_select,
    output logic [15:0]           drop_cnt,
    output logic                  busy
);

    recv_state_t           r_state;
    recv_state_t           w_next_state;
    logic [31:0]           r_data_q;
    logic                  r_en_q;
    logic [31:0]           r_hdr [HDR_LEN];
    logic [1:0]            r_hdr_cnt;
    logic [31:0]           r_offset;
    logic [31:0]           r_payload;
    logic [31:0]           r_cnt;
    logic [FS_W-1:0]       r_frame_select;
    logic [15:0]           r_drop_cnt;
    logic                  r_data_we;
    logic [35:0]           r_data_in;
    logic                  r_busy;

    logic [31:0]           w_words;
    logic                  w_addr_drop;
    logic [FS_W-1:0]       w_slot;
    logic [ADDR_WIDTH-1:0] w_base;
    logic                  w_write;
    logic                  w_trunc;
    logic [31:0]           w_issue_words;
    logic                  w_load;
    logic                  w_rotate;
    logic                  w_drop_inc;
    logic                  w_split_last;
    logic                  w_unused;

    // Read-side handshake is always ready; the write side is not used
    assign r_ack    = 1'b1;
    assign w_req    = 1'b0;
    assign w_enable = 1'b0;
    assign w_data   = 32'd0;
    assign w_unused = ^{r_req, w_ack, r_hdr[0], r_hdr[1], r_hdr[2]};

    assign data_in      = r_data_in;
    assign data_we      = r_data_we;
    assign frame_select = r_frame_select;
    assign drop_cnt     = r_drop_cnt;
    assign busy         = r_busy;

    // Input stage: the word and its enable travel together one cycle late
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= 32'd0;
            r_en_q   <= 1'b0;
        end else begin
            r_data_q <= r_data;
            r_en_q   <= r_enable;
        end
    end

    // Payload size, admission decision and target address of this packet
    always_comb begin
        w_words     = payload_words(r_hdr[HDR_L_IDX]);
        w_addr_drop = !r_en_q || (w_words == 32'd0) ||
                      (w_words > 32'(MAX_WORDS)) || data_full;
        w_slot      = r_frame_select + FS_W'(1'b1);
        w_base      = ADDR_WIDTH'(w_slot) * ADDR_WIDTH'(FRAME_STRIDE) +
                      ADDR_WIDTH'({r_offset[29:0], 2'b00});
    end

    // Next-state and per-cycle control decisions
    always_comb begin
        w_next_state  = r_state;
        w_write       = 1'b0;
        w_trunc       = 1'b0;
        w_issue_words = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_enable && !r_en_q) begin
                    w_next_state = ST_HEADER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!r_en_q) begin
                    w_next_state = ST_DROP;
                end else if (r_hdr_cnt == 2'(HDR_LEN - 1)) begin
                    w_next_state = ST_ADDR;
                end else begin
                    w_next_state = ST_HEADER;
                end
            end
            ST_ADDR: begin
                if (w_addr_drop) begin
                    w_next_state = ST_DROP;
                end else begin
                    w_next_state = ST_RECV;
                end
            end
            ST_RECV: begin
                if (r_en_q) begin
                    w_write = 1'b1;
                    if ((r_cnt + 32'd1) == r_payload) begin
                        w_next_state  = ST_ISSUE;
                        w_issue_words = r_cnt + 32'd1;
                    end else begin
                        w_next_state = ST_RECV;
                    end
                end else if (r_cnt == 32'd0) begin
                    // Packet ended before any payload: nothing to command
                    w_next_state = ST_DROP;
                end else begin
                    w_next_state = ST_ISSUE;
                    w_trunc      = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (w_split_last) begin
                    w_next_state = ST_WAIT_END;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_WAIT_END, ST_DROP: begin
                if (!r_enable) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_load     = (r_state == ST_RECV) && (w_next_state == ST_ISSUE);
    assign w_rotate   = (r_state == ST_ADDR) && !w_addr_drop && (r_data_q == 32'd0);
    assign w_drop_inc = ((r_state == ST_DROP) && !r_enable) || w_trunc;

    // State register; busy is registered from the next state so it matches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    // Header capture, offset/payload latch and payload word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HDR_LEN; i++) begin
                r_hdr[i] <= 32'd0;
            end
            r_hdr_cnt <= 2'd0;
            r_offset  <= 32'd0;
            r_payload <= 32'd0;
            r_cnt     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hdr_cnt <= 2'd0;
                end
                ST_HEADER: begin
                    r_hdr[r_hdr_cnt] <= r_data_q;
                    r_hdr_cnt        <= r_hdr_cnt + 2'd1;
                end
                ST_ADDR: begin
                    r_offset  <= r_data_q;
                    r_payload <= w_words;
                    r_cnt     <= 32'd0;
                end
                ST_RECV: begin
                    if (w_write) begin
                        r_cnt <= r_cnt + 32'd1;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Displayed-frame rotation and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_select <= '0;
            r_drop_cnt     <= 16'd0;
        end else begin
            if (w_rotate) begin
                r_frame_select <= r_frame_select + FS_W'(1'b1);
            end else begin
                r_frame_select <= r_frame_select;
            end
            if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    // Registered data FIFO write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_we <= 1'b0;
            r_data_in <= 36'd0;
        end else begin
            r_data_we <= w_write;
            if (w_write) begin
                r_data_in <= {DATA_STRB, r_data_q};
            end else begin
                r_data_in <= r_data_in;
            end
        end
    end

    udp_burst_splitter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_splitter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_words     (w_issue_words),
        .i_base      (w_base),
        .i_issue     (r_state == ST_ISSUE),
        .i_ctrl_full (ctrl_full),
        .o_ctrl_in   (ctrl_in),
        .o_ctrl_we   (ctrl_we),
        .o_last      (w_split_last)
    );

endmodule

// File: tb/tb_udp_frame_dma_recv.sv
// Directed and randomized packets against a packet-level reference model.
module tb_udp_frame_dma_recv;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_req;
    logic        r_enable;
    logic        r_ack;
    logic [31:0] r_data;
    logic        w_req;
    logic        w_enable;
    logic        w_ack;
    logic [31:0] w_data;
    logic [35:0] data_in;
    logic        data_we;
    logic        data_full;
    logic [39:0] ctrl_in;
    logic        ctrl_we;
    logic        ctrl_full;
    logic [0:0]  frame_select;
    logic [15:0] drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    udp_frame_dma_recv dut (
        .clk          (clk),
        .rst          (rst),
        .r_req        (r_req),
        .r_enable     (r_enable),
        .r_ack        (r_ack),
        .r_data       (r_data),
        .w_req        (w_req),
        .w_enable     (w_enable),
        .w_ack        (w_ack),
        .w_data       (w_data),
        .data_in      (data_in),
        .data_we      (data_we),
        .data_full    (data_full),
        .ctrl_in      (ctrl_in),
        .ctrl_we      (ctrl_we),
        .ctrl_full    (ctrl_full),
        .frame_select (frame_select),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    int          n_chk  = 0;
    int          n_err  = 0;
    int          n_viol = 0;
    int          m_fs   = 0;
    int          m_drop = 0;
    logic [35:0] q_wr[$];
    logic [39:0] q_cmd[$];
    logic [31:0] exp_wr[$];
    logic [39:0] exp_cmd[$];

    // Monitor: record what the FIFOs would accept at the coming edge
    always @(negedge clk) begin
        if (data_we) q_wr.push_back(data_in);
        if (ctrl_we && !ctrl_full) q_cmd.push_back(ctrl_in);
        if (ctrl_we && ctrl_full) n_viol++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] hmix(input logic [63:0] h, input logic [35:0] v);
        return {h[58:0], h[63:59]} ^ {28'd0, v};
    endfunction

    task automatic drive_word(input logic [31:0] d, input int stall);
        r_enable  = 1'b1;
        r_data    = d;
        ctrl_full = (stall == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
        tick();
    endtask

    // One packet: header (word 3 = L), offset O, nsent payload words
    task automatic run_packet(input logic [31:0] len, input logic [31:0] off,
                              input int nsent, input int stall, input logic dfull);
        longint      p;
        bit          drop;
        bit          trunc;
        bit          stalled;
        int          nw;
        int          guard;
        logic [31:0] base;
        logic [31:0] pay[$];
        logic [63:0] h_got;
        logic [63:0] h_exp;
        q_wr.delete(); q_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
        for (int i = 0; i < nsent; i++) pay.push_back($urandom);
        // Reference model
        p     = ((longint'(len) + 64'sd3) / 64'sd4) - 64'sd2;
        drop  = (p <= 0) || (p > 512) || dfull;
        trunc = !drop && (nsent < p);
        nw    = drop ? 0 : (trunc ? nsent : int'(p));
        if (drop || trunc) m_drop++;
        if (!drop && off == 32'd0) m_fs = (m_fs + 1) % 2;
        base = 32'((m_fs + 1) % 2) * 32'h0200_0000 + off * 32'd4;
        for (int i = 0; i < nw; i++) exp_wr.push_back(pay[i]);
        for (int rem = nw, k = 0; rem > 0; rem -= 64, k++)
            exp_cmd.push_back({8'((rem > 64) ? 64 : rem), base + 32'(k * 256)});
        // Stimulus
        data_full = dfull;
        for (int i = 0; i < 3; i++) drive_word($urandom, stall);
        drive_word(len, stall);
        drive_word(off, stall);
        for (int i = 0; i < nsent; i++) drive_word(pay[i], stall);
        r_enable = 1'b0;
        r_data   = 32'd0;
        guard    = 0;
        stalled  = 1'b0;
        while (busy && guard < 3000) begin
            if (stall == 2 && !stalled && q_cmd.size() == 1 && exp_cmd.size() > 1) begin
                stalled   = 1'b1;
                ctrl_full = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_hold", {ctrl_we, ctrl_in}, {1'b0, exp_cmd[1]});
                    tick();
                end
                ctrl_full = 1'b0;
            end else begin
                ctrl_full = (stall == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            tick();
            guard++;
        end
        ctrl_full = 1'b0;
        data_full = 1'b0;
        tick();
        tick();
        chk("done_in_budget", guard < 3000, 1'b1);
        chk("wr_count", q_wr.size(), exp_wr.size());
        h_got = 64'd0;
        h_exp = 64'd0;
        foreach (q_wr[i]) h_got = hmix(h_got, q_wr[i]);
        foreach (exp_wr[i]) h_exp = hmix(h_exp, {4'hF, exp_wr[i]});
        chk("wr_data_hash", h_got, h_exp);
        chk("cmd_count", q_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < q_cmd.size(); i++)
            chk("cmd", q_cmd[i], exp_cmd[i]);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("frame_select", frame_select, m_fs);
        chk("ctrl_we_while_full", n_viol, 0);
    endtask

    initial begin
        logic [31:0] len;
        logic [31:0] off;
        longint      pp;
        int          ns;
        rst = 1'b1; r_req = 1'b1; r_enable = 1'b0; r_data = 32'd0;
        w_ack = 1'b0; data_full = 1'b0; ctrl_full = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", {data_we, data_in}, 37'd0);
        chk("rst_ctrl", {ctrl_we, ctrl_in}, 41'd0);
        chk("rst_status", {busy, frame_select, drop_cnt}, 18'd0);
        chk("r_ack", r_ack, 1'b1);
        chk("w_side", {w_req, w_enable, w_data}, 34'd0);
        tick();

        run_packet(32'd1032, 32'h100, 256, 0, 1'b0);   // four full bursts
        run_packet(32'd20, 32'd0, 3, 0, 1'b0);         // rotate to frame 1
        run_packet(32'd20, 32'd0, 3, 0, 1'b0);         // rotate back to 0
        run_packet(32'd4096, 32'h10, 5, 0, 1'b0);      // oversize drop
        run_packet(32'd1032, 32'h100, 256, 2, 1'b0);   // stall mid-issue
        run_packet(32'd1032, 32'h80, 10, 0, 1'b0);     // truncated after 10
        run_packet(32'd100, 32'd5, 23, 0, 1'b1);       // data FIFO full drop
        run_packet(32'd5, 32'd7, 2, 0, 1'b0);          // P == 0 drop
        run_packet(32'd2056, 32'd9, 512, 1, 1'b0);     // exactly MAX_WORDS
        run_packet(32'd2060, 32'd9, 3, 0, 1'b0);       // MAX_WORDS + 1 drop
        run_packet(32'd40, 32'd3, 15, 1, 1'b0);        // packet longer than L

        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(20, 2200);
            off = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
            pp  = ((longint'(len) + 64'sd3) / 64'sd4) - 64'sd2;
            if (pp < 1 || pp > 512) ns = 4;
            else begin
                case ($urandom_range(0, 2))
                    0: ns = int'(pp);
                    1: ns = int'(pp) + 3;
                    default: ns = (pp > 1) ? $urandom_range(1, int'(pp) - 1) : int'(pp);
                endcase
            end
            run_packet(len, off, ns, 1, 1'b0);
        end

        // Reset in the middle of the payload
        run_packet(32'd20, 32'd0, 3, 0, 1'b0);         // leave frame_select nonzero state
        q_wr.delete(); q_cmd.delete();
        for (int i = 0; i < 3; i++) drive_word($urandom, 0);
        drive_word(32'd1032, 0);
        drive_word(32'h40, 0);
        for (int i = 0; i < 20; i++) drive_word($urandom, 0);
        rst = 1'b1; r_enable = 1'b0; r_data = 32'd0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_data", {data_we, data_in}, 37'd0);
        chk("rst_mid_ctrl", {ctrl_we, ctrl_in}, 41'd0);
        chk("rst_mid_status", {busy, frame_select, drop_cnt}, 18'd0);
        m_fs = 0;
        m_drop = 0;
        q_cmd.delete();
        for (int i = 0; i < 20; i++) tick();
        chk("rst_mid_no_cmd", q_cmd.size(), 0);
        run_packet(32'd1032, 32'h100, 256, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
